// File: rtl/mm_arb_pkg.sv
// rtl/mm_arb_pkg.sv - shared types and constants for the external bus arbiter
package mm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_XFER = 2'd1,
      DMA_XFER = 2'd2
   } arb_state_t;

   localparam int MST_CPU = 0;
   localparam int MST_DMA = 1;

   localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
   localparam int          EXT_ADDR_MSB = 13;

   // Peripheral space is everything outside the low 8 KiB
   function automatic logic is_ext_addr(input logic [15:0] addr);
      return |addr[15:EXT_ADDR_MSB];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way grant picker, fixed CPU priority or round-robin on last grant
module rr_arb2
   import mm_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       prio_mode,
   input  logic       grant_en,
   output logic [1:0] gnt
);

   logic r_last_dma;

   always_comb begin
      gnt = 2'b00;
      if (grant_en) begin
         if (req[MST_CPU] && req[MST_DMA]) begin
            if (prio_mode || r_last_dma) begin
               gnt[MST_CPU] = 1'b1;
            end else begin
               gnt[MST_DMA] = 1'b1;
            end
         end else begin
            gnt = req;
         end
      end
   end

   // Reset to DMA so the first tie goes to the CPU
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_dma <= 1'b1;
      end else if (|gnt) begin
         r_last_dma <= gnt[MST_DMA];
      end
   end

endmodule

// File: rtl/mm_bus_arbiter.sv
// rtl/mm_bus_arbiter.sv - CPU/DMA arbiter for the external peripheral bus; wait-state watchdog under MM_ARB_TIMEOUT_EN
module mm_bus_arbiter
   import mm_arb_pkg::*;
#(
   parameter int CPU_PRIO    = 0,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_re,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_wdata,
   output logic [15:0] dma_rdata,
   output logic        dma_done,
   output logic        bus_re,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   input  logic [15:0] bus_rdata,
   input  logic        bus_rdy,
   output logic        bus_err
);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic        w_cpu_req;
   logic        w_grant_en;
   logic [1:0]  w_gnt;
   logic        w_busy;
   logic        w_timeout;
   logic        w_xfer_end;
   logic [15:0] w_rd_data;
   logic        r_bus_re;
   logic        r_bus_we;
   logic [15:0] r_bus_addr;
   logic [15:0] r_bus_wdata;

   assign w_cpu_req  = cpu_re | cpu_we;
   assign w_grant_en = (r_state == IDLE);
   assign w_busy     = (r_state != IDLE);

   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({dma_req, w_cpu_req}),
      .prio_mode (CPU_PRIO != 0),
      .grant_en  (w_grant_en),
      .gnt       (w_gnt)
   );

`ifdef MM_ARB_TIMEOUT_EN
   logic [7:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || !w_busy) begin
         r_wait_cnt <= 8'd0;
      end else if (!bus_rdy) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   assign w_timeout = w_busy && !bus_rdy && (r_wait_cnt == TIMEOUT_CYC[7:0]);
`else
   // No watchdog: a limit below zero can never be reached
   assign w_timeout = (TIMEOUT_CYC < 0);
`endif

   // A reset cycle never reports completion, even if the peripheral is ready
   assign w_xfer_end = w_busy && rst_n && (bus_rdy || w_timeout);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_gnt[MST_CPU]) begin
               w_next = CPU_XFER;
            end else if (w_gnt[MST_DMA]) begin
               w_next = DMA_XFER;
            end
         end
         CPU_XFER, DMA_XFER: begin
            if (w_xfer_end) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Write wins when the CPU raises both strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bus_re    <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 16'h0000;
         r_bus_wdata <= 16'h0000;
      end else if (w_gnt[MST_CPU]) begin
         r_bus_re    <= ~cpu_we;
         r_bus_we    <= cpu_we;
         r_bus_addr  <= cpu_addr;
         r_bus_wdata <= cpu_wdata;
      end else if (w_gnt[MST_DMA]) begin
         r_bus_re    <= ~dma_we;
         r_bus_we    <= dma_we;
         r_bus_addr  <= dma_addr;
         r_bus_wdata <= dma_wdata;
      end else if (w_xfer_end) begin
         r_bus_re    <= 1'b0;
         r_bus_we    <= 1'b0;
      end
   end

   always_comb begin
      cpu_done  = 1'b0;
      dma_done  = 1'b0;
      cpu_rdata = 16'h0000;
      dma_rdata = 16'h0000;
      bus_err   = w_timeout && rst_n;
      w_rd_data = w_timeout ? TIMEOUT_DATA : (r_bus_re ? bus_rdata : 16'h0000);
      if (w_xfer_end) begin
         if (r_state == CPU_XFER) begin
            cpu_done  = 1'b1;
            cpu_rdata = w_rd_data;
         end else if (r_state == DMA_XFER) begin
            dma_done  = 1'b1;
            dma_rdata = w_rd_data;
         end
      end
   end

   assign cpu_stall = w_cpu_req & ~cpu_done;
   assign bus_re    = r_bus_re;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// tb/tb_mm_bus_arbiter.sv - bench for mm_bus_arbiter: dut 0 round-robin, dut 1 CPU priority
module tb_mm_bus_arbiter;

`ifdef MM_ARB_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 64;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        cpu_re [2];
   logic        cpu_we [2];
   logic [15:0] cpu_addr [2];
   logic [15:0] cpu_wdata [2];
   logic [15:0] cpu_rdata [2];
   logic        cpu_done [2];
   logic        cpu_stall [2];
   logic        dma_req [2];
   logic        dma_we [2];
   logic [15:0] dma_addr [2];
   logic [15:0] dma_wdata [2];
   logic [15:0] dma_rdata [2];
   logic        dma_done [2];
   logic        bus_re [2];
   logic        bus_we [2];
   logic [15:0] bus_addr [2];
   logic [15:0] bus_wdata [2];
   logic [15:0] bus_rdata [2];
   logic        bus_rdy [2];
   logic        bus_err [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mm_bus_arbiter #(.CPU_PRIO(g), .TIMEOUT_CYC(TO)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .cpu_re(cpu_re[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
         .cpu_rdata(cpu_rdata[g]), .cpu_done(cpu_done[g]), .cpu_stall(cpu_stall[g]),
         .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]), .dma_wdata(dma_wdata[g]),
         .dma_rdata(dma_rdata[g]), .dma_done(dma_done[g]),
         .bus_re(bus_re[g]), .bus_we(bus_we[g]), .bus_addr(bus_addr[g]), .bus_wdata(bus_wdata[g]),
         .bus_rdata(bus_rdata[g]), .bus_rdy(bus_rdy[g]), .bus_err(bus_err[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;
   int order[$];

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h want %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transfer per arbiter, described by who owns it
   bit          m_busy [2];
   bit          m_dma [2];
   bit          m_we [2];
   bit          m_last_dma [2];
   logic [15:0] m_addr [2];
   logic [15:0] m_wdata [2];
   int          m_wait [2];

   function automatic bit m_timeout(input int k);
      bit lim;
`ifdef MM_ARB_TIMEOUT_EN
      lim = (m_wait[k] == TO);
`else
      lim = 1'b0;
`endif
      return m_busy[k] && !bus_rdy[k] && lim;
   endfunction

   function automatic bit m_finish(input int k);
      return rst_n && m_busy[k] && (bus_rdy[k] || m_timeout(k));
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit c, d, pick_dma;
         c = cpu_re[k] | cpu_we[k];
         d = dma_req[k];
         if (!rst_n) begin
            m_busy[k]     <= 1'b0;
            m_last_dma[k] <= 1'b1;
            m_addr[k]     <= 16'h0;
            m_wdata[k]    <= 16'h0;
            m_wait[k]     <= 0;
         end else if (m_busy[k]) begin
            if (m_finish(k)) m_busy[k] <= 1'b0;
            else if (!bus_rdy[k]) m_wait[k] <= m_wait[k] + 1;
         end else if (c || d) begin
            if (c && d) pick_dma = (k == 1) ? 1'b0 : !m_last_dma[k];
            else pick_dma = d;
            m_busy[k]     <= 1'b1;
            m_dma[k]      <= pick_dma;
            m_last_dma[k] <= pick_dma;
            m_wait[k]     <= 0;
            m_we[k]       <= pick_dma ? dma_we[k] : cpu_we[k];
            m_addr[k]     <= pick_dma ? dma_addr[k] : cpu_addr[k];
            m_wdata[k]    <= pick_dma ? dma_wdata[k] : cpu_wdata[k];
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            bit cd, dd;
            logic [15:0] rd;
            cd = m_finish(k) && !m_dma[k];
            dd = m_finish(k) && m_dma[k];
            rd = m_timeout(k) ? 16'hDEAD : (m_we[k] ? 16'h0 : bus_rdata[k]);
            chk("cpu_done", k, cpu_done[k], cd);
            chk("dma_done", k, dma_done[k], dd);
            chk("cpu_rdata", k, cpu_rdata[k], cd ? rd : 16'h0);
            chk("dma_rdata", k, dma_rdata[k], dd ? rd : 16'h0);
            chk("cpu_stall", k, cpu_stall[k], (cpu_re[k] | cpu_we[k]) && !cd);
            chk("bus_re", k, bus_re[k], m_busy[k] && !m_we[k]);
            chk("bus_we", k, bus_we[k], m_busy[k] && m_we[k]);
            chk("bus_err", k, bus_err[k], rst_n && m_timeout(k));
            if (m_busy[k]) begin
               chk("bus_addr", k, bus_addr[k], m_addr[k]);
               chk("bus_wdata", k, bus_wdata[k], m_wdata[k]);
            end
         end
      end
   end

   task automatic cpu_do(input int k, input bit re, input bit we, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd);
      int n;
      n = 0;
      rd = 16'hxxxx;
      cpu_re[k] = re; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = wd;
      forever begin
         @(negedge clk);
         if (cpu_done[k]) begin
            rd = cpu_rdata[k];
            order.push_back(0);
            break;
         end
         n++;
         if (n > 40) begin
            n_vec++; n_err++;
            $display("FAIL cpu_wait dut%0d: got no cpu_done want done within 40 cycles", k);
            break;
         end
      end
      @(posedge clk); #1;
      cpu_re[k] = 1'b0; cpu_we[k] = 1'b0;
   endtask

   task automatic dma_do(input int k, input bit we, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd);
      int n;
      n = 0;
      rd = 16'hxxxx;
      dma_req[k] = 1'b1; dma_we[k] = we; dma_addr[k] = a; dma_wdata[k] = wd;
      forever begin
         @(negedge clk);
         if (dma_done[k]) begin
            rd = dma_rdata[k];
            order.push_back(1);
            break;
         end
         n++;
         if (n > 40) begin
            n_vec++; n_err++;
            $display("FAIL dma_wait dut%0d: got no dma_done want done within 40 cycles", k);
            break;
         end
      end
      @(posedge clk); #1;
      dma_req[k] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [15:0] rd_c, rd_d;
      int cnt, cnt2, bad, at;
      int exp_rr[5];
      int exp_pr[3];
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cpu_re[k] = 0; cpu_we[k] = 0; cpu_addr[k] = 0; cpu_wdata[k] = 0;
         dma_req[k] = 0; dma_we[k] = 0; dma_addr[k] = 0; dma_wdata[k] = 0;
         bus_rdata[k] = 0; bus_rdy[k] = 1;
      end

      // Reset values; stall follows the request even in reset
      @(posedge clk); #1;
      started = 1'b1;
      cpu_we[0] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_bus_re", k, bus_re[k], 0);
         chk("rst_bus_we", k, bus_we[k], 0);
         chk("rst_bus_addr", k, bus_addr[k], 0);
         chk("rst_bus_wdata", k, bus_wdata[k], 0);
         chk("rst_done", k, {cpu_done[k], dma_done[k], bus_err[k]}, 0);
      end
      chk("rst_stall", 0, cpu_stall[0], 1);
      @(posedge clk); #1;
      cpu_we[0] = 1'b0;
      rst_n = 1'b1;

      // Zero-wait CPU read
      @(posedge clk); #1;
      cpu_re[1] = 1'b1; cpu_addr[1] = 16'hC004; bus_rdata[1] = 16'h1234;
      cnt = 0;
      @(negedge clk);
      chk("t1_re_idle", 1, bus_re[1], 0);
      if (cpu_stall[1]) cnt++;
      @(negedge clk);
      chk("t1_re", 1, bus_re[1], 1);
      chk("t1_addr", 1, bus_addr[1], 16'hC004);
      chk("t1_done", 1, cpu_done[1], 1);
      chk("t1_rdata", 1, cpu_rdata[1], 16'h1234);
      if (cpu_stall[1]) cnt++;
      @(posedge clk); #1;
      cpu_re[1] = 1'b0;
      @(negedge clk);
      chk("t1_re_off", 1, bus_re[1], 0);
      if (cpu_stall[1]) cnt++;
      chk("t1_stall_cycles", 1, cnt, 1);

      // Round-robin order: tie, lone CPU, tie (CPU read+write -> write)
      @(posedge clk); #1;
      bus_rdata[0] = 16'h7777;
      order.delete();
      fork
         cpu_do(0, 1'b0, 1'b1, 16'h2000, 16'h1111, rd_c);
         dma_do(0, 1'b0, 16'h4000, 16'h0000, rd_d);
      join
      chk("t2_dma_rd", 0, rd_d, 16'h7777);
      cpu_do(0, 1'b1, 1'b0, 16'h2002, 16'h0000, rd_c);
      chk("t2_cpu_rd", 0, rd_c, 16'h7777);
      fork
         cpu_do(0, 1'b1, 1'b1, 16'h2004, 16'h2222, rd_c);
         dma_do(0, 1'b1, 16'h4002, 16'h3333, rd_d);
      join
      chk("t2_rw_rdata", 0, rd_c, 16'h0000);
      exp_rr = '{0, 1, 0, 1, 0};
      chk("t2_len", 0, order.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++) chk("t2_order", 0, order[i], exp_rr[i]);

      // Fixed priority: CPU write arrives mid-DMA, beats the next DMA request
      bus_rdata[1] = 16'h0BAD;
      order.delete();
      cnt = 0;
      fork
         repeat (2) dma_do(1, 1'b0, 16'h9000, 16'h0000, rd_d);
         begin
            @(posedge clk); #1;
            cpu_do(1, 1'b0, 1'b1, 16'hE000, 16'h00FF, rd_c);
         end
         repeat (10) @(negedge clk) if (cpu_stall[1]) cnt++;
      join
      exp_pr = '{1, 0, 1};
      chk("t3_len", 1, order.size(), 3);
      for (int i = 0; i < 3 && i < order.size(); i++) chk("t3_order", 1, order[i], exp_pr[i]);
      chk("t3_stall_cycles", 1, cnt, 2);

      // Five wait states on a DMA read
      bus_rdata[0] = 16'hBEEF;
      cnt = 0; cnt2 = 0; bad = 0;
      fork
         dma_do(0, 1'b0, 16'h8010, 16'h0000, rd_d);
         begin
            bus_rdy[0] = 1'b0;
            repeat (6) @(posedge clk);
            #1 bus_rdy[0] = 1'b1;
         end
         repeat (10) @(negedge clk) begin
            if (bus_re[0]) begin
               cnt++;
               if (bus_addr[0] !== 16'h8010) bad++;
            end
            if (dma_done[0]) cnt2++;
         end
      join
      chk("t4_re_cycles", 0, cnt, 6);
      chk("t4_addr_unstable", 0, bad, 0);
      chk("t4_done_count", 0, cnt2, 1);
      chk("t4_rdata", 0, rd_d, 16'hBEEF);

      // Reset in the middle of a CPU transfer
      @(posedge clk); #1;
      bus_rdy[1] = 1'b0; bus_rdata[1] = 16'h5A5A;
      cpu_re[1] = 1'b1; cpu_addr[1] = 16'hA002;
      @(posedge clk); #1;
      chk("t5_granted", 1, bus_re[1], 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_no_done", 1, cpu_done[1], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t5_re_cleared", 1, {bus_re[1], bus_we[1], cpu_done[1]}, 0);
      bus_rdy[1] = 1'b1;
      at = 0;
      for (int i = 1; i <= 10 && at == 0; i++) begin
         @(negedge clk);
         if (cpu_done[1]) begin
            at = i;
            chk("t5_reissue_rdata", 1, cpu_rdata[1], 16'h5A5A);
         end
      end
      chk("t5_reissue_latency", 1, at, 2);
      @(posedge clk); #1;
      cpu_re[1] = 1'b0;

      // Peripheral that never answers
      @(posedge clk); #1;
      bus_rdy[0] = 1'b0; bus_rdata[0] = 16'h0000;
      cpu_re[0] = 1'b1; cpu_addr[0] = 16'h6000;
`ifdef MM_ARB_TIMEOUT_EN
      at = 0;
      for (int i = 1; i <= 12 && at == 0; i++) begin
         @(negedge clk);
         if (cpu_done[0]) begin
            at = i;
            chk("t6_rdata", 0, cpu_rdata[0], 16'hDEAD);
            chk("t6_bus_err", 0, bus_err[0], 1);
         end
      end
      chk("t6_done_at", 0, at, 6);
      @(posedge clk); #1;
      cpu_re[0] = 1'b0;
      bus_rdy[0] = 1'b1;
      @(negedge clk);
      chk("t6_err_pulse", 0, bus_err[0], 0);
`else
      cnt = 0; cnt2 = 0;
      repeat (20) begin
         @(negedge clk);
         if (cpu_stall[0]) cnt++;
         if (cpu_done[0] || bus_err[0]) cnt2++;
      end
      chk("t6_stall_held", 0, cnt, 20);
      chk("t6_no_done", 0, cnt2, 0);
      @(posedge clk); #1;
      bus_rdy[0] = 1'b1;
      at = 0;
      for (int i = 1; i <= 5 && at == 0; i++) begin
         @(negedge clk);
         if (cpu_done[0]) at = i;
      end
      chk("t6_release", 0, at, 1);
      @(posedge clk); #1;
      cpu_re[0] = 1'b0;
`endif
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
